// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding, packet type codes, layout helpers and meta field offsets
package serializer_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE_RD, ISSUE_WR, WR_DATA, LEN_ERR} state_t;
  localparam logic WRITE = 1'b1;
  localparam logic READ = 1'b0;
  localparam int OFF_REGION = 0;
  localparam int OFF_QOS = 4;
  localparam int OFF_PROT = 8;
  localparam int OFF_CACHE = 11;
  localparam int OFF_LOCK = 15;
  localparam int OFF_BURST = 16;
  localparam int OFF_SIZE = 18;
  localparam int OFF_LEN = 21;
  localparam int OFF_ID = 29;
  function automatic int meta_w(input int addr_w, input int id_w, input int user_w);
    return addr_w + id_w + 29 + user_w;
  endfunction
  function automatic int pkt_w(input int addr_w, input int id_w, input int user_w, input int data_w, input int max_beats);
    return 1 + meta_w(addr_w, id_w, user_w) + max_beats * (data_w / 8) + max_beats * data_w;
  endfunction
endpackage

// File: rtl/outstanding_tracker.sv
// outstanding_tracker: saturating in-flight transaction counter with full flag
module outstanding_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down_b,
  input  logic             down_r,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  int drained, nxt;
  assign full = int'(count) >= MAX_OUTSTANDING;
  // responses arriving with nothing in flight are dropped before the new issue is added
  always_comb begin
    drained = int'(count) - int'(down_b) - int'(down_r);
    nxt = (drained < 0 ? 0 : drained) + int'(up);
  end
  // counter register, clamped at the configured ceiling
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= nxt > MAX_OUTSTANDING ? CNT_W'(MAX_OUTSTANDING) : CNT_W'(nxt);
endmodule

// File: rtl/burst_serializer.sv
// burst_serializer: turns one flattened packet into a full AXI4 read or write burst
module burst_serializer
  import serializer_pkg::*;
#(
  parameter int ID_W = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int USER_W = 1,
  parameter int MAX_BEATS = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int META_W = meta_w(ADDR_W, ID_W, USER_W),
  localparam int PKT_W = pkt_w(ADDR_W, ID_W, USER_W, DATA_W, MAX_BEATS),
  localparam int STRB_W = DATA_W / 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,
  input  logic              valid,
  output logic              ready,
  input  logic [PKT_W-1:0]  packet,
  output logic [ID_W-1:0]   M_AXI_AWID,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_AWLOCK,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [2:0]        M_AXI_AWPROT,
  output logic [3:0]        M_AXI_AWQOS,
  output logic [3:0]        M_AXI_AWREGION,
  output logic [USER_W-1:0] M_AXI_AWUSER,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [STRB_W-1:0] M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARLOCK,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [2:0]        M_AXI_ARPROT,
  output logic [3:0]        M_AXI_ARQOS,
  output logic [3:0]        M_AXI_ARREGION,
  output logic [USER_W-1:0] M_AXI_ARUSER,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic              resp_err,
  output logic              len_err,
  output logic [CNT_W-1:0]  outstanding
);
  localparam int BEAT_W = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
  localparam int META_LSB = MAX_BEATS * (DATA_W + STRB_W);
  state_t state, nxt;
  logic [PKT_W-2:0] pkt_q;
  logic [META_W-1:0] meta;
  logic [BEAT_W-1:0] beat_idx;
  logic [DATA_W-1:0] beat_data [MAX_BEATS];
  logic [STRB_W-1:0] beat_strb [MAX_BEATS];
  logic w_done, full, accept, w_hs, w_last_hs, unused;
  assign meta = pkt_q[META_LSB +: META_W];
  for (genvar b = 0; b < MAX_BEATS; b++) begin : g_beat
    assign beat_data[b] = pkt_q[(MAX_BEATS - 1 - b) * DATA_W +: DATA_W];
    assign beat_strb[b] = pkt_q[MAX_BEATS * DATA_W + (MAX_BEATS - 1 - b) * STRB_W +: STRB_W];
  end
  assign M_AXI_AWUSER = meta[0 +: USER_W];
  assign M_AXI_AWREGION = meta[USER_W + OFF_REGION +: 4];
  assign M_AXI_AWQOS = meta[USER_W + OFF_QOS +: 4];
  assign M_AXI_AWPROT = meta[USER_W + OFF_PROT +: 3];
  assign M_AXI_AWCACHE = meta[USER_W + OFF_CACHE +: 4];
  assign M_AXI_AWLOCK = meta[USER_W + OFF_LOCK];
  assign M_AXI_AWBURST = meta[USER_W + OFF_BURST +: 2];
  assign M_AXI_AWSIZE = meta[USER_W + OFF_SIZE +: 3];
  assign M_AXI_AWLEN = meta[USER_W + OFF_LEN +: 8];
  assign M_AXI_AWID = meta[USER_W + OFF_ID +: ID_W];
  assign M_AXI_AWADDR = meta[USER_W + OFF_ID + ID_W +: ADDR_W];
  assign M_AXI_ARUSER = M_AXI_AWUSER;
  assign M_AXI_ARREGION = M_AXI_AWREGION;
  assign M_AXI_ARQOS = M_AXI_AWQOS;
  assign M_AXI_ARPROT = M_AXI_AWPROT;
  assign M_AXI_ARCACHE = M_AXI_AWCACHE;
  assign M_AXI_ARLOCK = M_AXI_AWLOCK;
  assign M_AXI_ARBURST = M_AXI_AWBURST;
  assign M_AXI_ARSIZE = M_AXI_AWSIZE;
  assign M_AXI_ARLEN = M_AXI_AWLEN;
  assign M_AXI_ARID = M_AXI_AWID;
  assign M_AXI_ARADDR = M_AXI_AWADDR;
  assign ready = state == IDLE && !full;
  assign accept = valid && ready;
  assign M_AXI_AWVALID = state == ISSUE_WR;
  assign M_AXI_ARVALID = state == ISSUE_RD;
  assign M_AXI_WVALID = (state == ISSUE_WR && !w_done) || state == WR_DATA;
  assign M_AXI_WDATA = beat_data[beat_idx];
  assign M_AXI_WSTRB = beat_strb[beat_idx];
  assign M_AXI_WLAST = M_AXI_WVALID && 8'(beat_idx) == M_AXI_AWLEN;
  assign M_AXI_BREADY = !M_AXI_ARESET;
  assign M_AXI_RREADY = !M_AXI_ARESET;
  assign len_err = state == LEN_ERR;
  assign w_hs = M_AXI_WVALID && M_AXI_WREADY;
  assign w_last_hs = w_hs && M_AXI_WLAST;
  assign unused = &{1'b0, M_AXI_BRESP[0], M_AXI_RRESP[0]};
  outstanding_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_tracker (
    .clk(M_AXI_ACLK),
    .rst(M_AXI_ARESET),
    .up((M_AXI_AWVALID && M_AXI_AWREADY) || (M_AXI_ARVALID && M_AXI_ARREADY)),
    .down_b(M_AXI_BVALID && M_AXI_BREADY),
    .down_r(M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST),
    .count(outstanding),
    .full(full)
  );
  // next state: the write leaves ISSUE_WR only once AW is done, finishing directly if WLAST already went
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = int'(packet[META_LSB + USER_W + OFF_LEN +: 8]) >= MAX_BEATS ? LEN_ERR : packet[PKT_W-1] == WRITE ? ISSUE_WR : ISSUE_RD;
      ISSUE_RD: if (M_AXI_ARREADY) nxt = IDLE;
      ISSUE_WR: if (M_AXI_AWREADY) nxt = (w_done || w_last_hs) ? IDLE : WR_DATA;
      WR_DATA: if (w_last_hs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, packet latch, beat pointer and registered error pulse
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
    if (M_AXI_ARESET) begin
      state <= IDLE;
      pkt_q <= '0;
      beat_idx <= '0;
      w_done <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state <= nxt;
      resp_err <= (M_AXI_BVALID && M_AXI_BRESP[1]) || (M_AXI_RVALID && M_AXI_RRESP[1]);
      if (accept) begin
        pkt_q <= packet[PKT_W-2:0];
        beat_idx <= '0;
        w_done <= 1'b0;
      end else begin
        if (w_hs && !M_AXI_WLAST) beat_idx <= beat_idx + 1'b1;
        if (state == ISSUE_WR && w_last_hs) w_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_burst_serializer.sv
// tb_burst_serializer: directed stimulus with a transaction-level reference model and per-cycle compare
module tb_burst_serializer;
  localparam int ID_W = 16, ADDR_W = 32, DW = 128, USER_W = 1, MB = 4, MO = 2;
  localparam int SW = DW / 8;
  localparam int META_W = ADDR_W + ID_W + 29 + USER_W;
  localparam int PKT_W = 1 + META_W + MB * SW + MB * DW;

  typedef struct packed {
    logic wr;
    logic [31:0] addr;
    logic [15:0] id;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic user;
    logic [MB-1:0][DW-1:0] data;
    logic [MB-1:0][SW-1:0] strb;
  } pkt_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic l;
  } beat_t;

  logic clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic ready;
  logic [PKT_W-1:0] packet = '0;
  logic [15:0] awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst;
  logic awlock, arlock, awuser, aruser;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic awvalid, wlast, wvalid, bready, arvalid, rready, resp_err, len_err;
  logic awready = 1'b1, wready = 1'b1, arready = 1'b1;
  logic bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [1:0] outstanding;

  int n_chk = 0, n_err = 0;
  pkt_t cur = '0, m_cur = '0;
  beat_t wq[$];
  logic m_aw = 1'b0, m_ar = 1'b0, m_le = 1'b0, m_re = 1'b0, m_acc;
  int m_out = 0, m_drained;

  burst_serializer #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DW), .USER_W(USER_W), .MAX_BEATS(MB), .MAX_OUTSTANDING(MO)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .valid(valid), .ready(ready), .packet(packet),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWQOS(awqos), .M_AXI_AWREGION(awregion), .M_AXI_AWUSER(awuser),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .resp_err(resp_err), .len_err(len_err), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  function automatic logic [META_W-1:0] meta_of(input pkt_t p);
    return {p.addr, p.id, p.len, p.size, p.burst, p.lock, p.cache, p.prot, p.qos, p.region, p.user};
  endfunction

  function automatic logic [PKT_W-1:0] pack(input pkt_t p);
    logic [PKT_W-1:0] v;
    v = {p.wr, meta_of(p), {(MB * (SW + DW)){1'b0}}};
    for (int i = 0; i < MB; i++) begin
      v[MB * DW + (MB - 1 - i) * SW +: SW] = p.strb[i];
      v[(MB - 1 - i) * DW +: DW] = p.data[i];
    end
    return v;
  endfunction

  function automatic pkt_t mk(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic [7:0] seed);
    pkt_t p;
    p = '0;
    p.wr = wr; p.addr = addr; p.id = {8'h01, seed}; p.len = len; p.size = 3'd4; p.burst = 2'b01;
    p.lock = seed[1]; p.cache = 4'h3; p.prot = 3'd2; p.qos = seed[3:0]; p.region = seed[7:4]; p.user = seed[0];
    for (int i = 0; i < MB; i++) begin
      p.data[i] = {16{seed + 8'(i)}};
      p.strb[i] = 16'hFFFF >> (4 * i);
    end
    return p;
  endfunction

  function automatic logic m_ready();
    return !(m_aw || m_ar || m_le || wq.size() != 0) && m_out < MO;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input pkt_t p);
    int k;
    cur = p;
    packet = pack(p);
    valid = 1'b1;
    k = 0;
    while (!ready && k < 50) begin
      to_pos();
      k++;
    end
    n_chk++;
    if (!ready) begin
      n_err++;
      $display("FAIL send_timeout: ready got 0 expected 1 at %0t", $time);
    end
    to_pos();
    valid = 1'b0;
  endtask

  // reference model: pending address phases, queue of expected W beats, in-flight count
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_aw = 1'b0; m_ar = 1'b0; m_le = 1'b0; m_re = 1'b0; m_out = 0;
      wq.delete();
    end else begin
      m_acc = valid && m_ready();
      m_drained = m_out - (bvalid ? 1 : 0) - ((rvalid && rlast) ? 1 : 0);
      m_out = (m_drained < 0 ? 0 : m_drained) + (((m_aw && awready) || (m_ar && arready)) ? 1 : 0);
      m_re = (bvalid && bresp[1]) || (rvalid && rresp[1]);
      if (m_aw && awready) m_aw = 1'b0;
      if (m_ar && arready) m_ar = 1'b0;
      if (wq.size() != 0 && wready) void'(wq.pop_front());
      m_le = 1'b0;
      if (m_acc) begin
        if (int'(cur.len) + 1 > MB) m_le = 1'b1;
        else begin
          m_cur = cur;
          if (cur.wr) begin
            m_aw = 1'b1;
            for (int i = 0; i <= int'(cur.len); i++) wq.push_back('{cur.data[i], cur.strb[i], i == int'(cur.len)});
          end else m_ar = 1'b1;
        end
      end
    end

  // per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    chk("ready", ready, m_ready());
    chk("awvalid", awvalid, m_aw);
    chk("arvalid", arvalid, m_ar);
    chk("wvalid", wvalid, wq.size() != 0);
    chk("len_err", len_err, m_le);
    chk("resp_err", resp_err, m_re);
    chk("outstanding", outstanding, m_out);
    chk("bready", bready, !rst);
    chk("rready", rready, !rst);
    if (m_aw) chk("aw_meta", {awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser}, meta_of(m_cur));
    if (m_ar) chk("ar_meta", {araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser}, meta_of(m_cur));
    if (wq.size() != 0) begin
      chk("wdata", wdata, wq[0].d);
      chk("wstrb", wstrb, wq[0].s);
      chk("wlast", wlast, wq[0].l);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0); chk("rst_wlast", wlast, 0);
    chk("rst_arvalid", arvalid, 0); chk("rst_bready", bready, 0); chk("rst_rready", rready, 0);
    chk("rst_outstanding", outstanding, 0); chk("rst_ready", ready, 1);
    chk("rst_wdata", wdata, 0); chk("rst_wstrb", wstrb, 0);
    to_pos();
    rst = 1'b0;
    to_pos();
    // single-beat write
    send(mk(1'b1, 32'h1000, 8'd0, 8'hA5));
    @(negedge clk);
    chk("t1_awvalid", awvalid, 1); chk("t1_wvalid", wvalid, 1); chk("t1_wlast", wlast, 1);
    chk("t1_awaddr", awaddr, 32'h1000); chk("t1_wdata", wdata, {16{8'hA5}}); chk("t1_wstrb", wstrb, 16'hFFFF);
    chk("t1_ready_busy", ready, 0);
    to_pos();
    @(negedge clk);
    chk("t1_ready_back", ready, 1); chk("t1_out1", outstanding, 1);
    to_pos(); bvalid = 1'b1; bresp = 2'b00;
    to_pos(); bvalid = 1'b0;
    @(negedge clk);
    chk("t1_out0", outstanding, 0);
    to_pos();
    // 4-beat write with a 3-cycle stall on beat 1
    send(mk(1'b1, 32'h2000, 8'd3, 8'h10));
    to_pos(); wready = 1'b0;
    @(negedge clk);
    chk("t2_stall_data", wdata, {16{8'h11}}); chk("t2_stall_last", wlast, 0);
    repeat (2) to_pos();
    @(negedge clk);
    chk("t2_stall_hold", wdata, {16{8'h11}});
    to_pos(); wready = 1'b1;
    to_pos();
    to_pos();
    @(negedge clk);
    chk("t2_beat3", wdata, {16{8'h13}}); chk("t2_wlast", wlast, 1); chk("t2_strb3", wstrb, 16'h000F);
    to_pos();
    @(negedge clk);
    chk("t2_ready", ready, 1); chk("t2_out", outstanding, 1);
    to_pos(); bvalid = 1'b1;
    to_pos(); bvalid = 1'b0;
    // read with ARREADY held off for two cycles
    arready = 1'b0;
    send(mk(1'b0, 32'h3000, 8'd3, 8'h30));
    @(negedge clk); chk("t3_ar1", arvalid, 1);
    to_pos();
    @(negedge clk); chk("t3_ar2", arvalid, 1);
    to_pos(); arready = 1'b1;
    @(negedge clk); chk("t3_ar3", arvalid, 1); chk("t3_araddr", araddr, 32'h3000); chk("t3_arlen", arlen, 3);
    to_pos();
    @(negedge clk); chk("t3_ar_done", arvalid, 0); chk("t3_out1", outstanding, 1); chk("t3_ready", ready, 1);
    to_pos(); rvalid = 1'b1; rlast = 1'b0;
    repeat (3) to_pos();
    rlast = 1'b1;
    to_pos(); rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk); chk("t3_out0", outstanding, 0);
    to_pos();
    // two reads fill the outstanding budget
    send(mk(1'b0, 32'h4000, 8'd0, 8'h40));
    send(mk(1'b0, 32'h4100, 8'd1, 8'h41));
    to_pos();
    @(negedge clk); chk("t4_full_ready", ready, 0); chk("t4_out2", outstanding, 2);
    to_pos(); rvalid = 1'b1; rlast = 1'b1;
    to_pos(); rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk); chk("t4_ready_again", ready, 1); chk("t4_out1", outstanding, 1);
    to_pos(); rvalid = 1'b1; rlast = 1'b1; rresp = 2'b11;
    to_pos(); rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    @(negedge clk); chk("t4_decerr", resp_err, 1); chk("t4_out0", outstanding, 0);
    to_pos();
    // over-long packet
    send(mk(1'b1, 32'h5000, 8'd7, 8'h50));
    @(negedge clk);
    chk("t5_len_err", len_err, 1); chk("t5_awvalid", awvalid, 0); chk("t5_wvalid", wvalid, 0);
    chk("t5_arvalid", arvalid, 0); chk("t5_ready_busy", ready, 0);
    to_pos();
    @(negedge clk); chk("t5_len_err_low", len_err, 0); chk("t5_ready", ready, 1); chk("t5_out", outstanding, 0);
    to_pos();
    // reset in the middle of a 4-beat write
    send(mk(1'b1, 32'h6000, 8'd3, 8'h60));
    to_pos();
    to_pos();
    rst = 1'b1;
    #1;
    chk("t6_wvalid", wvalid, 0); chk("t6_awvalid", awvalid, 0); chk("t6_out", outstanding, 0); chk("t6_ready", ready, 1);
    to_pos(); rst = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    to_pos(); bvalid = 1'b0;
    @(negedge clk); chk("t6_stale_b", outstanding, 0);
    to_pos();
    send(mk(1'b1, 32'h6100, 8'd1, 8'h61));
    repeat (2) to_pos();
    @(negedge clk); chk("t6_after_ready", ready, 1); chk("t6_after_out", outstanding, 1);
    to_pos(); bvalid = 1'b1;
    to_pos(); bvalid = 1'b0;
    // SLVERR write response
    send(mk(1'b1, 32'h7000, 8'd0, 8'h70));
    to_pos(); bvalid = 1'b1; bresp = 2'b10;
    to_pos(); bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk); chk("t7_resp_err", resp_err, 1); chk("t7_out", outstanding, 0);
    to_pos();
    @(negedge clk); chk("t7_pulse_end", resp_err, 0);
    repeat (3) to_pos();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
